// File: rtl/score_pkg.sv
// Shared types and constants for the score display controller.
package score_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // Segment patterns {a,b,c,d,e,f,g,dp}, active-low; dp is always off.
  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h09;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Codes A-F never come out of a BCD counter; they are shown dark.
  function automatic logic [7:0] seg_decode(input logic [BCD_W-1:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/score_display_if.sv
// Bundle of game event pulses and display/score outputs.
interface score_display_if
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic                        game_start;
  logic                        score_inc;
  logic                        game_over;
  logic [NUM_DIGITS-1:0]       anode;
  logic [7:0]                  cathode;
  logic [BCD_W*NUM_DIGITS-1:0] score_bcd;
  logic [BCD_W*NUM_DIGITS-1:0] high_bcd;
  logic                        new_high;
  logic [1:0]                  state;

  // Game logic side: raises events, watches the score.
  modport master (
    output game_start, score_inc, game_over,
    input  anode, cathode, score_bcd, high_bcd, new_high, state
  );

  // Controller side.
  modport slave (
    input  game_start, score_inc, game_over,
    output anode, cathode, score_bcd, high_bcd, new_high, state
  );

endinterface

// File: rtl/score_display_ctrl_bcd_digit.sv
// One decimal digit of the score counter; digits chain through carry_out.
module bcd_digit_cnt
  import score_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_in,
  input  logic             inc_in,
  input  logic             sat_in,
  output logic             carry_out,
  output logic [BCD_W-1:0] digit_out,
  output logic [BCD_W-1:0] nxt_out
);

  logic [BCD_W-1:0] r_digit;
  logic             w_at_max;

  assign w_at_max  = (r_digit == BCD_MAX);
  // Carry is raised whether or not the increment lands, so the top digit's
  // carry can be fed back as the saturation flag without a loop.
  assign carry_out = inc_in && w_at_max;
  assign digit_out = r_digit;

  // Next digit value; exported so the high-score compare can see a same-cycle increment.
  always_comb begin
    nxt_out = r_digit;
    if (clr_in) begin
      nxt_out = '0;
    end else if (inc_in && !sat_in) begin
      nxt_out = w_at_max ? '0 : r_digit + BCD_W'(1);
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_digit <= '0;
    end else begin
      r_digit <= nxt_out;
    end
  end

endmodule

// File: rtl/score_display_ctrl.sv
// Score keeper, high-score register and multiplexed seven-segment driver.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a game; display shows the high score
// ST_PLAY | game running; score_inc counts, display shows the score
// ST_OVER | game ended; display shows the score, flashing on a new high
module score_display_ctrl
  import score_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV_BITS  = 18,
  parameter int FLASH_DIV_BITS = 25,
  parameter int BLANK_LEADING  = 1
) (
  input logic            clk,
  input logic            rst,
  score_display_if.slave bus
);

  localparam int SCORE_W = BCD_W * NUM_DIGITS;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // One bit wider than FLASH_DIV_BITS so each lit/dark phase lasts 2^FLASH_DIV_BITS cycles.
  localparam int FLASH_W = FLASH_DIV_BITS + 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_start_game;
  logic                  w_enter_over;
  logic                  w_inc_en;

  logic [SCORE_W-1:0]    w_score;
  logic [SCORE_W-1:0]    w_score_nxt;
  logic [SCORE_W-1:0]    r_high;
  logic [SCORE_W-1:0]    w_disp;
  logic                  r_new_high;
  logic                  w_sat;

  logic [SCAN_DIV_BITS-1:0] r_scan_cnt;
  logic                     w_scan_tc;
  logic [IDX_W-1:0]         r_digit_idx;
  logic [FLASH_W-1:0]       r_flash_cnt;
  logic                     w_flash_dark;

  logic [NUM_DIGITS-1:0] r_anode;
  logic [NUM_DIGITS-1:0] w_anode_nxt;
  logic [7:0]            r_cathode;
  logic [7:0]            w_cathode_nxt;

  // Score counter: digit 0 takes the increment, higher digits take the carry below.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic w_inc_in;
    logic w_carry;

    if (g == 0) begin : g_lsd
      assign w_inc_in = w_inc_en;
    end else begin : g_upper
      assign w_inc_in = g_digit[g-1].w_carry;
    end

    bcd_digit_cnt u_digit (
      .clk       (clk),
      .rst       (rst),
      .clr_in    (w_start_game),
      .inc_in    (w_inc_in),
      .sat_in    (w_sat),
      .carry_out (w_carry),
      .digit_out (w_score[g*BCD_W +: BCD_W]),
      .nxt_out   (w_score_nxt[g*BCD_W +: BCD_W])
    );
  end

  // An increment that would carry out of the top digit is dropped, holding all 9s.
  assign w_sat = g_digit[NUM_DIGITS-1].w_carry;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-transition strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_start_game = 1'b0;
    w_enter_over = 1'b0;
    w_inc_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.game_start) begin
          w_state_nxt  = ST_PLAY;
          w_start_game = 1'b1;
        end
      end
      ST_PLAY: begin
        w_inc_en = bus.score_inc;
        if (bus.game_over) begin
          w_state_nxt  = ST_OVER;
          w_enter_over = 1'b1;
        end
      end
      ST_OVER: begin
        if (bus.game_start) begin
          w_state_nxt  = ST_PLAY;
          w_start_game = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // High score latches on entry to OVER, comparing against the score including any same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_high     <= '0;
      r_new_high <= 1'b0;
    end else if (w_start_game) begin
      r_new_high <= 1'b0;
    end else if (w_enter_over && (w_score_nxt > r_high)) begin
      r_high     <= w_score_nxt;
      r_new_high <= 1'b1;
    end
  end

  // Flash phase runs only in OVER; held at zero elsewhere so each entry starts lit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flash_cnt <= '0;
    end else if (r_state == ST_OVER) begin
      r_flash_cnt <= r_flash_cnt + FLASH_W'(1);
    end else begin
      r_flash_cnt <= '0;
    end
  end

  assign w_flash_dark = (r_state == ST_OVER) && r_new_high && r_flash_cnt[FLASH_W-1];
  assign w_scan_tc    = &r_scan_cnt;

  // Scan prescaler and digit index; explicit wrap keeps non-power-of-2 digit counts correct.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= '0;
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_DIV_BITS'(1);
      if (w_scan_tc) begin
        if (r_digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
          r_digit_idx <= '0;
        end else begin
          r_digit_idx <= r_digit_idx + IDX_W'(1);
        end
      end
    end
  end

  assign w_disp = (r_state == ST_IDLE) ? r_high : w_score;

  // Select the current digit; walking down from the top tracks whether all higher digits are zero.
  always_comb begin
    logic l_zero_run;
    logic l_blank;
    w_anode_nxt   = '1;
    w_cathode_nxt = SEG_BLANK;
    l_zero_run    = 1'b1;
    l_blank       = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      l_zero_run = l_zero_run && (w_disp[i*BCD_W +: BCD_W] == '0);
      if (IDX_W'(i) == r_digit_idx) begin
        l_blank = (BLANK_LEADING != 0) && (i != 0) && l_zero_run;
        if (!l_blank && !w_flash_dark) begin
          w_anode_nxt[i] = 1'b0;
          w_cathode_nxt  = seg_decode(w_disp[i*BCD_W +: BCD_W]);
        end
      end
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_anode   <= '1;
      r_cathode <= SEG_BLANK;
    end else begin
      r_anode   <= w_anode_nxt;
      r_cathode <= w_cathode_nxt;
    end
  end

  assign bus.anode     = r_anode;
  assign bus.cathode   = r_cathode;
  assign bus.score_bcd = w_score;
  assign bus.high_bcd  = r_high;
  assign bus.new_high  = r_new_high;
  assign bus.state     = r_state;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl in three configurations.
module tb_score_display_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [7:0] C_SEG0   = 8'h03;
  localparam logic [7:0] C_SEG2   = 8'h25;
  localparam logic [7:0] C_SEGOFF = 8'hFF;

  score_display_if #(.NUM_DIGITS(4)) if4 ();
  score_display_if #(.NUM_DIGITS(2)) if2 ();
  score_display_if #(.NUM_DIGITS(3)) if3 ();

  score_display_ctrl #(
    .NUM_DIGITS(4), .SCAN_DIV_BITS(2), .FLASH_DIV_BITS(4), .BLANK_LEADING(1)
  ) u_dut4 (.clk(clk), .rst(rst_n), .bus(if4));

  score_display_ctrl #(
    .NUM_DIGITS(2), .SCAN_DIV_BITS(2), .FLASH_DIV_BITS(4), .BLANK_LEADING(1)
  ) u_dut2 (.clk(clk), .rst(rst_n), .bus(if2));

  score_display_ctrl #(
    .NUM_DIGITS(3), .SCAN_DIV_BITS(2), .FLASH_DIV_BITS(4), .BLANK_LEADING(0)
  ) u_dut3 (.clk(clk), .rst(rst_n), .bus(if3));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start4();
    if4.game_start = 1'b1;
    tick();
    if4.game_start = 1'b0;
  endtask

  task automatic inc4(input int n);
    if4.score_inc = 1'b1;
    repeat (n) tick();
    if4.score_inc = 1'b0;
  endtask

  task automatic lit_window4(output int lit);
    lit = 0;
    repeat (16) begin
      tick();
      if (if4.anode != 4'hF) lit++;
    end
  endtask

  initial begin
    int         lit;
    int         n_off;
    logic [2:0] exp3;
    logic [7:0] cat_seen [4];

    rst_n = 1'b1;
    if4.game_start = 0; if4.score_inc = 0; if4.game_over = 0;
    if2.game_start = 0; if2.score_inc = 0; if2.game_over = 0;
    if3.game_start = 0; if3.score_inc = 0; if3.game_over = 0;
    #1 rst_n = 1'b0;
    repeat (3) tick();

    check_eq("rst anode4", if4.anode, 4'hF);
    check_eq("rst cathode4", if4.cathode, C_SEGOFF);
    check_eq("rst state4", if4.state, 0);
    check_eq("rst score4", if4.score_bcd, 0);
    check_eq("rst high4", if4.high_bcd, 0);
    check_eq("rst new_high4", if4.new_high, 0);
    check_eq("rst anode3", if3.anode, 3'b111);

    rst_n = 1'b1;
    lit = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp3 = ~(3'b001 << (((k - 1) / 4) % 3));
      check_eq($sformatf("scan3 k=%0d", k), if3.anode, exp3);
      if (if4.anode != 4'hF) begin
        lit++;
        check_eq("idle4 lit anode", if4.anode, 4'hE);
        check_eq("idle4 lit cathode", if4.cathode, C_SEG0);
      end
    end
    check_eq("scan3 cathode", if3.cathode, C_SEG0);
    check_eq("idle4 lit count", lit, 4);

    if4.score_inc = 1'b1; if4.game_over = 1'b1;
    tick();
    if4.score_inc = 1'b0; if4.game_over = 1'b0;
    check_eq("idle ignores inc", if4.score_bcd, 0);
    check_eq("idle ignores over", if4.state, 0);

    start4();
    check_eq("start state", if4.state, 1);
    inc4(199);
    check_eq("score 199", if4.score_bcd, 16'h0199);
    inc4(1);
    check_eq("score 200", if4.score_bcd, 16'h0200);
    start4();
    check_eq("play ignores start state", if4.state, 1);
    check_eq("play ignores start score", if4.score_bcd, 16'h0200);

    tick();
    n_off = 0;
    for (int i = 0; i < 4; i++) cat_seen[i] = C_SEGOFF;
    repeat (16) begin
      tick();
      case (if4.anode)
        4'hE:    cat_seen[0] = if4.cathode;
        4'hD:    cat_seen[1] = if4.cathode;
        4'hB:    cat_seen[2] = if4.cathode;
        4'h7:    cat_seen[3] = if4.cathode;
        4'hF:    n_off++;
        default: n_off += 100;
      endcase
    end
    check_eq("200 digit0", cat_seen[0], C_SEG0);
    check_eq("200 digit1", cat_seen[1], C_SEG0);
    check_eq("200 digit2", cat_seen[2], C_SEG2);
    check_eq("200 digit3 blank", cat_seen[3], C_SEGOFF);
    check_eq("200 dark count", n_off, 4);

    if4.game_over = 1'b1;
    tick();
    if4.game_over = 1'b0;
    check_eq("over state", if4.state, 2);
    check_eq("over high 200", if4.high_bcd, 16'h0200);
    check_eq("over new_high", if4.new_high, 1);

    if2.game_start = 1'b1;
    tick();
    if2.game_start = 1'b0;
    if2.score_inc = 1'b1;
    repeat (105) tick();
    if2.score_inc = 1'b0;
    check_eq("sat score2", if2.score_bcd, 8'h99);
    check_eq("sat state2", if2.state, 1);

    check_eq("dut3 lit before reset", (if3.anode == 3'b111), 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async anode3", if3.anode, 3'b111);
    check_eq("async anode4", if4.anode, 4'hF);
    check_eq("async cathode4", if4.cathode, C_SEGOFF);
    check_eq("async state4", if4.state, 0);
    check_eq("async high4", if4.high_bcd, 0);
    check_eq("async new_high4", if4.new_high, 0);
    check_eq("async score2", if2.score_bcd, 0);
    @(negedge clk);
    rst_n = 1'b1;

    start4();
    inc4(41);
    check_eq("score 41", if4.score_bcd, 16'h0041);
    if4.score_inc = 1'b1; if4.game_over = 1'b1;
    tick();
    if4.score_inc = 1'b0;
    check_eq("simul score", if4.score_bcd, 16'h0042);
    check_eq("simul state", if4.state, 2);
    check_eq("simul high", if4.high_bcd, 16'h0042);
    check_eq("simul new_high", if4.new_high, 1);
    lit_window4(lit);
    check_eq("flash win1 lit", lit, 8);
    lit_window4(lit);
    check_eq("flash win2 lit", lit, 0);
    lit_window4(lit);
    check_eq("flash win3 lit", lit, 8);
    if4.game_over = 1'b0;

    start4();
    check_eq("game2 state", if4.state, 1);
    check_eq("game2 score clr", if4.score_bcd, 0);
    check_eq("game2 new_high clr", if4.new_high, 0);
    inc4(7);
    if4.game_over = 1'b1;
    tick();
    if4.game_over = 1'b0;
    check_eq("low state", if4.state, 2);
    check_eq("low score", if4.score_bcd, 16'h0007);
    check_eq("low high kept", if4.high_bcd, 16'h0042);
    check_eq("low new_high", if4.new_high, 0);
    lit_window4(lit);
    check_eq("low win1 lit", lit, 4);
    lit_window4(lit);
    check_eq("low win2 lit", lit, 4);
    inc4(1);
    check_eq("over ignores inc", if4.score_bcd, 16'h0007);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("final high clr", if4.high_bcd, 0);
    check_eq("final state", if4.state, 0);
    check_eq("final score", if4.score_bcd, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
